fight_data_control: RTL

Turn-based battle engine for the fight scene. It consumes the per-player stats produced by the selection stage (HP, speed, three skill damages for each player). It runs the attack/turn state machine from the player's key presses and publishes live HP, turn, skill cursor and the winner. Downstream consumers are the fight display and the scene controller, which moves to win_scene on fight_over.

---
 rtl/pokemon_pkg.sv | 38 +++
 rtl/fight_lfsr.sv | 22 ++
 rtl/fight_data_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pokemon_pkg.sv
// Shared scene codes, fight FSM encoding, winner codes and HP arithmetic helpers
// for the pokemon battle pipeline.
package pokemon_pkg;

  localparam int HP_W = 8;

  localparam logic [3:0] SCENE_START  = 4'b0000;
  localparam logic [3:0] SCENE_CHOOSE = 4'b0001;
  localparam logic [3:0] SCENE_FIGHT  = 4'b0011;
  localparam logic [3:0] SCENE_WIN    = 4'b0100;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SELECT = 3'd2,
    ST_APPLY  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } fight_state_t;

  // HP never wraps: a hit larger than the remaining HP leaves exactly zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                               input logic [HP_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

  function automatic logic [HP_W-1:0] sat_dbl(input logic [HP_W-1:0] a);
    return a[HP_W-1] ? '1 : {a[HP_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/fight_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), loaded with seed on reset.
module fight_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else if (en) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/fight_data_control.sv
// Turn-based battle engine: loads player stats, runs the select/apply/wait/check
// loop from key presses and reports live HP and the winner. FIGHT_CRIT_EN adds critical hits.
module fight_data_control
  import pokemon_pkg::*;
#(
  parameter int         ANIM_CYCLES = 25_000_000,
  parameter int         CNT_W       = 25,
  parameter logic [3:0] FIGHT_SCENE = 4'b0011
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   scene_state,
  input  logic         key_C,
  input  logic         key_L,
  input  logic         key_R,
  input  logic [7:0]   p1_pokemon_hp,
  input  logic [7:0]   p1_pokemon_speed,
  input  logic [7:0]   p1_skill_1_damage,
  input  logic [7:0]   p1_skill_2_damage,
  input  logic [7:0]   p1_skill_3_damage,
  input  logic [7:0]   p2_pokemon_hp,
  input  logic [7:0]   p2_pokemon_speed,
  input  logic [7:0]   p2_skill_1_damage,
  input  logic [7:0]   p2_skill_2_damage,
  input  logic [7:0]   p2_skill_3_damage,
  output logic [7:0]   p1_cur_hp,
  output logic [7:0]   p2_cur_hp,
  output logic         turn,
  output logic [1:0]   skill_sel,
  output logic         attack_valid,
  output logic         fight_over,
  output logic [1:0]   winner,
`ifdef FIGHT_CRIT_EN
  output logic         crit,
`endif
  output fight_state_t state_dbg
);

  // Keys are single-cycle pulses; handshake is implicit: a key is consumed in the
  // cycle it is high only if the FSM is in SELECT and it is the only key high.
  fight_state_t     state, state_next;
  logic [CNT_W-1:0] counter_q;
  logic [HP_W-1:0]  dmg_q;
  logic [HP_W-1:0]  sel_dmg;
  logic [HP_W-1:0]  eff_dmg;
  logic [HP_W-1:0]  defender_hp;
  logic             scene_active;
  logic             single_key;
  logic             anim_done;

  assign scene_active = (scene_state == FIGHT_SCENE);
  assign single_key   = (key_C ^ key_L ^ key_R) & ~(key_C & key_L & key_R);
  assign defender_hp  = turn ? p1_cur_hp : p2_cur_hp;
  assign anim_done    = (counter_q == CNT_W'(ANIM_CYCLES - 1));
  assign state_dbg    = state;

  always_comb begin
    sel_dmg = turn ? p2_skill_1_damage : p1_skill_1_damage;
    case (skill_sel)
      2'd2:    sel_dmg = turn ? p2_skill_2_damage : p1_skill_2_damage;
      2'd3:    sel_dmg = turn ? p2_skill_3_damage : p1_skill_3_damage;
      default: ;
    endcase
  end

`ifdef FIGHT_CRIT_EN
  logic [7:0] lfsr;
  logic       crit_hit;

  fight_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr)
  );

  assign crit_hit = (lfsr[2:0] == 3'd0);
  assign eff_dmg  = crit_hit ? sat_dbl(dmg_q) : dmg_q;
`else
  assign eff_dmg  = dmg_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leaving the fight scene aborts from any active state back to IDLE.
  always_comb begin
    state_next = state;
    if (state != ST_IDLE && !scene_active) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (scene_active) state_next = ST_LOAD;
        ST_LOAD:   state_next = ST_SELECT;
        ST_SELECT: if (key_C && single_key) state_next = ST_APPLY;
        ST_APPLY:  state_next = ST_WAIT;
        ST_WAIT:   if (anim_done) state_next = ST_CHECK;
        ST_CHECK:  state_next = (defender_hp == '0) ? ST_DONE : ST_SELECT;
        ST_DONE:   state_next = ST_DONE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    attack_valid = (state == ST_APPLY) && scene_active;
    fight_over   = (state == ST_DONE);
`ifdef FIGHT_CRIT_EN
    crit         = attack_valid && crit_hit;
`endif
  end

  // HP and winner are only written while the fight scene is active, so they
  // survive an abort for the win scene to read.
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_cur_hp <= '0;
      p2_cur_hp <= '0;
      turn      <= 1'b0;
      skill_sel <= 2'd1;
      winner    <= WIN_NONE;
      counter_q <= '0;
      dmg_q     <= '0;
    end else if (scene_active) begin
      case (state)
        ST_LOAD: begin
          p1_cur_hp <= p1_pokemon_hp;
          p2_cur_hp <= p2_pokemon_hp;
          turn      <= (p2_pokemon_speed > p1_pokemon_speed);
          skill_sel <= 2'd1;
          winner    <= WIN_NONE;
        end
        ST_SELECT: begin
          if (single_key) begin
            if (key_L && skill_sel != 2'd1) skill_sel <= skill_sel - 2'd1;
            if (key_R && skill_sel != 2'd3) skill_sel <= skill_sel + 2'd1;
            if (key_C) dmg_q <= sel_dmg;
          end
        end
        ST_APPLY: begin
          if (turn) p1_cur_hp <= sat_sub(p1_cur_hp, eff_dmg);
          else      p2_cur_hp <= sat_sub(p2_cur_hp, eff_dmg);
          counter_q <= '0;
        end
        ST_WAIT: counter_q <= counter_q + 1'b1;
        ST_CHECK: begin
          if (defender_hp == '0) begin
            winner <= turn ? WIN_P2 : WIN_P1;
          end else begin
            turn      <= ~turn;
            skill_sel <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
